// File: rtl/dmem_mmio.sv
// Word-addressed data RAM plus peripheral page at 0xC000_0000 (switches, LEDs, debounced button).
// Optional 32-bit free-running timer at page offset 0x000C when DMEM_TIMER_EN is defined.
module dmem_mmio #(
    parameter int unsigned RAM_WORDS       = 64,
    parameter int unsigned SW_W            = 10,
    parameter int unsigned LED_W           = 10,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter string       INIT_FILE       = "dmem.dat"
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              we,
    input  logic [31:0]       a,
    input  logic [31:0]       wd,
    output logic [31:0]       rd,
    input  logic [SW_W-1:0]   switches,
    input  logic              button,
    output logic [LED_W-1:0]  leds
);

    localparam int unsigned AW       = $clog2(RAM_WORDS);
    localparam int unsigned CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [13:0] OFF_SW   = 14'h0000;
    localparam logic [13:0] OFF_LED  = 14'h0001;
    localparam logic [13:0] OFF_BTN  = 14'h0002;
    localparam logic [13:0] OFF_TMR  = 14'h0003;

    logic [31:0]       mem_q [RAM_WORDS];
    logic [SW_W-1:0]   sw_s1_q, sw_s2_q;
    logic              btn_s1_q, btn_s2_q;
    logic              db_q, db_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              flag_q, flag_d;
    logic [7:0]        pcnt_q, pcnt_d;
    logic [LED_W-1:0]  leds_q, leds_d;
    logic              page_sel;
    logic [13:0]       off;
    logic              wr_led, wr_btn, press;
    logic [31:0]       tmr_rd;
    logic              unused_addr_bits;

    assign page_sel         = (a[31:16] == 16'hC000);
    assign off              = a[15:2];
    assign wr_led           = we & page_sel & (off == OFF_LED);
    assign wr_btn           = we & page_sel & (off == OFF_BTN);
    assign unused_addr_bits = ^a[1:0];
    assign leds             = leds_q;

    always_ff @(posedge clk) begin
        if (we && !page_sel) mem_q[a[AW+1:2]] <= wd;
    end

    // Debounce: level flips only after DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
        db_d   = db_q;
        cnt_d  = '0;
        flag_d = flag_q;
        pcnt_d = pcnt_q;
        leds_d = leds_q;
        if (btn_s2_q != db_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) db_d = ~db_q;
            else                                    cnt_d = cnt_q + CW'(1);
        end
        press = db_d & ~db_q;
        // A press event takes priority over a simultaneous software clear.
        if (press)                flag_d = 1'b1;
        else if (wr_btn && wd[1]) flag_d = 1'b0;
        if (press)                pcnt_d = pcnt_q + 8'd1;
        else if (wr_btn && wd[2]) pcnt_d = 8'd0;
        if (wr_led) leds_d = wd[LED_W-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sw_s1_q  <= '0;
            sw_s2_q  <= '0;
            btn_s1_q <= 1'b0;
            btn_s2_q <= 1'b0;
            db_q     <= 1'b0;
            cnt_q    <= '0;
            flag_q   <= 1'b0;
            pcnt_q   <= 8'd0;
            leds_q   <= '0;
        end else begin
            sw_s1_q  <= switches;
            sw_s2_q  <= sw_s1_q;
            btn_s1_q <= button;
            btn_s2_q <= btn_s1_q;
            db_q     <= db_d;
            cnt_q    <= cnt_d;
            flag_q   <= flag_d;
            pcnt_q   <= pcnt_d;
            leds_q   <= leds_d;
        end
    end

`ifdef DMEM_TIMER_EN
    logic [31:0] tmr_q;
    logic        wr_tmr;

    assign wr_tmr = we & page_sel & (off == OFF_TMR);
    assign tmr_rd = tmr_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    tmr_q <= 32'd0;
        else if (wr_tmr) tmr_q <= wd;
        else             tmr_q <= tmr_q + 32'd1;
    end
`else
    assign tmr_rd = 32'd0;
`endif

    // Combinational read mux; shows pre-edge state during a write.
    always_comb begin
        rd = 32'd0;
        if (page_sel) begin
            case (off)
                OFF_SW:  rd = 32'(sw_s2_q);
                OFF_LED: rd = 32'(leds_q);
                OFF_BTN: rd = {16'h0000, pcnt_q, 6'b000000, flag_q, db_q};
                OFF_TMR: rd = tmr_rd;
                default: rd = 32'd0;
            endcase
        end else begin
            rd = mem_q[a[AW+1:2]];
        end
    end

endmodule

// File: tb/tb_dmem_mmio.sv
// Scoreboard bench for dmem_mmio: stimulus pushes expectations, a negedge monitor pops and compares.
module tb_dmem_mmio;

    localparam logic [31:0] A_SW  = 32'hC000_0000;
    localparam logic [31:0] A_LED = 32'hC000_0004;
    localparam logic [31:0] A_BTN = 32'hC000_0008;
    localparam logic [31:0] A_TMR = 32'hC000_000C;
    localparam int          DEB   = 16;

    logic        clk, reset_n, we, button;
    logic [31:0] a, wd, rd;
    logic [9:0]  switches, leds;

    dmem_mmio #(
        .RAM_WORDS(64), .SW_W(10), .LED_W(10), .DEBOUNCE_CYCLES(DEB), .INIT_FILE("")
    ) dut (
        .clk(clk), .reset_n(reset_n), .we(we), .a(a), .wd(wd), .rd(rd),
        .switches(switches), .button(button), .leds(leds)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [32:0] val_q [$];
    string       nm_q  [$];
    logic        chk_v;
    int          n_cmp, n_err;

    logic [31:0] ram_m [64];
    bit          wr_m  [64];
    logic [9:0]  led_m;
    logic [7:0]  cnt_m;

    // Monitor: one expectation consumed per flagged cycle.
    logic [32:0] mon_e;
    string       mon_nm;
    logic [31:0] mon_act;
    always @(negedge clk) begin
        if (chk_v) begin
            n_cmp++;
            if (val_q.size() == 0) begin
                n_err++;
                $display("FAIL scoreboard_underflow: got rd=%h expected a queued entry", rd);
            end else begin
                mon_e   = val_q.pop_front();
                mon_nm  = nm_q.pop_front();
                mon_act = mon_e[32] ? 32'(leds) : rd;
                if (mon_act !== mon_e[31:0]) begin
                    n_err++;
                    $display("FAIL %s: got %h expected %h", mon_nm, mon_act, mon_e[31:0]);
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] btn_word(input logic lvl, input logic flg, input logic [7:0] c);
        return {16'h0000, c, 6'b000000, flg, lvl};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        chk_v = 1'b0;
        we    = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
        a = addr; wd = data; we = 1'b1;
        step();
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [31:0] exp, input string nm);
        a = addr; we = 1'b0;
        val_q.push_back({1'b0, exp});
        nm_q.push_back(nm);
        chk_v = 1'b1;
        step();
    endtask

    task automatic led_chk(input logic [31:0] exp, input string nm);
        we = 1'b0;
        val_q.push_back({1'b1, exp});
        nm_q.push_back(nm);
        chk_v = 1'b1;
        step();
    endtask

    task automatic press_once();
        button = 1'b1;
        repeat (20) step();
        button = 1'b0;
        repeat (20) step();
        cnt_m = cnt_m + 8'd1;
    endtask

    initial begin
        logic [31:0] ad, ad2, d;
        logic [9:0]  sw_p1, sw_p2, sw_n;
        int          idx;
        n_cmp = 0; n_err = 0; chk_v = 1'b0;
        reset_n = 1'b0; we = 1'b0; a = 32'd0; wd = 32'd0;
        switches = 10'd0; button = 1'b0;
        led_m = 10'd0; cnt_m = 8'd0;
        for (int i = 0; i < 64; i++) wr_m[i] = 1'b0;

        // Reset state
        step();
        led_chk(32'd0, "reset_leds");
        do_read(A_BTN, 32'd0, "reset_btn");
        do_read(A_LED, 32'd0, "reset_led_reg");
        do_read(A_SW, 32'd0, "reset_sw");
        reset_n = 1'b1;
        step();

        // RAM directed and wrap
        do_write(32'h0000_0004, 32'hDEAD_BEEF);
        ram_m[1] = 32'hDEAD_BEEF; wr_m[1] = 1'b1;
        do_read(32'h0000_0004, 32'hDEAD_BEEF, "ram_rdback");
        do_read(32'h0000_0104, 32'hDEAD_BEEF, "ram_wrap");

        // RAM random with aliased read addresses
        for (int i = 0; i < 60; i++) begin
            ad = $urandom;
            if (ad[31:16] == 16'hC000) ad[31:16] = 16'h0000;
            idx = int'(ad[7:2]);
            if (!wr_m[idx] || $urandom_range(0, 1) == 1) begin
                d = $urandom;
                do_write(ad, d);
                ram_m[idx] = d; wr_m[idx] = 1'b1;
            end
            ad2 = $urandom;
            ad2[7:2] = ad[7:2];
            if (ad2[31:16] == 16'hC000) ad2[31:16] = 16'h1234;
            do_read(ad2, ram_m[idx], "ram_rand");
        end

        // LED register, ignored writes, unmapped offsets
        do_write(A_LED, 32'hFFFF_FFFF);
        led_m = 10'h3FF;
        led_chk(32'h0000_03FF, "led_pin_all");
        do_read(A_LED, 32'h0000_03FF, "led_read_all");
        do_read(32'h0000_0004, ram_m[1], "page_write_not_ram");
        do_write(A_SW, 32'hFFFF_FFFF);
        do_read(A_SW, 32'd0, "sw_write_ignored");
        do_write(32'hC000_0010, 32'hFFFF_FFFF);
        do_read(32'hC000_0010, 32'd0, "unmapped_read");
        do_read(32'hC000_0100, 32'd0, "unmapped_read_hi");
        for (int i = 0; i < 6; i++) begin
            d = $urandom;
            do_write(A_LED, d);
            led_m = d[9:0];
            led_chk(32'(led_m), "led_pin_rand");
            do_read(A_LED, 32'(led_m), "led_read_rand");
        end

        // Switch latency: visible on the second read after the change
        switches = 10'h155;
        do_read(A_SW, 32'd0, "sw_lat0");
        do_read(A_SW, 32'd0, "sw_lat1");
        do_read(A_SW, 32'h155, "sw_lat2");
        sw_p1 = 10'h155; sw_p2 = 10'h155;
        for (int i = 0; i < 12; i++) begin
            sw_n = 10'($urandom);
            switches = sw_n;
            do_read(A_SW, 32'(sw_p2), "sw_rand");
            sw_p2 = sw_p1; sw_p1 = sw_n;
        end

        // Bounce: toggle every 3 cycles, no level change
        for (int i = 0; i < 40; i++) begin
            button = ((i / 3) % 2) == 1;
            do_read(A_BTN, 32'd0, "btn_bounce");
        end
        button = 1'b0;
        repeat (20) do_read(A_BTN, 32'd0, "btn_settle");

        // Clean hold: rises exactly 2 + DEB cycles later
        button = 1'b1;
        for (int i = 0; i < 2 + DEB; i++) do_read(A_BTN, 32'd0, "btn_before_rise");
        cnt_m = 8'd1;
        do_read(A_BTN, 32'h0000_0103, "btn_rise");
        button = 1'b0;
        repeat (20) step();
        do_read(A_BTN, btn_word(1'b0, 1'b1, cnt_m), "btn_released");
        do_write(A_BTN, 32'h0000_0002);
        do_read(A_BTN, btn_word(1'b0, 1'b0, cnt_m), "btn_flag_clear");
        do_write(A_BTN, 32'h0000_0004);
        cnt_m = 8'd0;
        do_read(A_BTN, 32'd0, "btn_cnt_clear");

        // Random glitches shorter than the debounce window
        for (int g = 0; g < 10; g++) begin
            button = 1'b1;
            repeat ($urandom_range(1, DEB - 1)) do_read(A_BTN, 32'd0, "btn_glitch");
            button = 1'b0;
            repeat ($urandom_range(2, 6)) do_read(A_BTN, 32'd0, "btn_glitch_gap");
        end
        repeat (4) do_read(A_BTN, 32'd0, "btn_glitch_end");

        // Drive count to 255, then collide a clear with the next press
        for (int p = 0; p < 255; p++) press_once();
        do_read(A_BTN, btn_word(1'b0, 1'b1, cnt_m), "btn_cnt255");
        do_write(A_BTN, 32'h0000_0002);
        do_read(A_BTN, btn_word(1'b0, 1'b0, cnt_m), "btn_cnt255_noflag");
        button = 1'b1;
        for (int i = 0; i < 1 + DEB; i++) do_read(A_BTN, btn_word(1'b0, 1'b0, 8'd255), "btn_pre_collide");
        do_write(A_BTN, 32'h0000_0006);
        do_read(A_BTN, btn_word(1'b1, 1'b1, 8'd0), "btn_collide");
        do_write(A_BTN, 32'h0000_0002);
        do_read(A_BTN, btn_word(1'b1, 1'b0, 8'd0), "btn_flag_clear_lvl1");
        button = 1'b0;
        repeat (22) step();
        do_read(A_BTN, 32'd0, "btn_after_collide");

        // Timer
`ifdef DMEM_TIMER_EN
        do_write(A_TMR, 32'hFFFF_FFFE);
        do_read(A_TMR, 32'hFFFF_FFFE, "tmr_load");
        do_read(A_TMR, 32'hFFFF_FFFF, "tmr_inc");
        do_read(A_TMR, 32'h0000_0000, "tmr_wrap");
`else
        do_write(A_TMR, 32'hFFFF_FFFE);
        do_read(A_TMR, 32'd0, "tmr_absent0");
        do_read(A_TMR, 32'd0, "tmr_absent1");
`endif

        // Reset in the middle of a debounce
        do_write(A_LED, 32'h0000_02AA);
        led_chk(32'h0000_02AA, "led_2aa");
        button = 1'b1;
        repeat (10) step();
        reset_n = 1'b0;
        led_chk(32'd0, "rst_mid_leds");
        do_read(A_BTN, 32'd0, "rst_mid_btn");
        do_read(A_LED, 32'd0, "rst_mid_led_reg");
        reset_n = 1'b1;
        for (int i = 0; i < 2 + DEB; i++) do_read(A_BTN, 32'd0, "rst_rel_before_rise");
        do_read(A_BTN, 32'h0000_0103, "rst_rel_rise");

        step();
        while (val_q.size() != 0) begin
            void'(val_q.pop_front());
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard_leftover: got unconsumed entry expected none");
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
